// File: rtl/microcode_sequencer.sv
// Control-store sequencer: copies boot microcode from EPROM into the
// control-store RAM after reset, then fetches and sequences microinstructions
// with next/branch/call/return addressing, datapath stall and halt.
module microcode_sequencer #(
    parameter int unsigned           ADDR_WIDTH  = 8,
    parameter int unsigned           WORD_WIDTH  = 64,
    parameter int unsigned           STACK_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] HALT_ADDR   = ADDR_WIDTH'(8'hFE)
) (
    input  logic                  clk,
    input  logic                  _reset,
    input  logic [WORD_WIDTH-1:0] rom_data,
    input  logic [WORD_WIDTH-1:0] cs_ram_data,
    output logic [WORD_WIDTH-1:0] cs_ram_wdata,
    output logic                  cs_ram__w,
    output logic [ADDR_WIDTH-1:0] cs_addr,
    output logic                  cs_ready,
    output logic [WORD_WIDTH-1:0] cs_word,
    input  logic [1:0]            seq_op,
    input  logic [ADDR_WIDTH-1:0] next_field,
    input  logic                  cond,
    input  logic [ADDR_WIDTH-1:0] ir,
    input  logic                  stall,
    output logic                  halted,
    output logic                  stack_err
);

    localparam int unsigned     SP_W    = $clog2(STACK_DEPTH + 1);
    localparam int unsigned     IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

    localparam logic [2:0] S_LOAD_WR  = 3'd0;
    localparam logic [2:0] S_LOAD_ADV = 3'd1;
    localparam logic [2:0] S_FETCH    = 3'd2;
    localparam logic [2:0] S_EXEC     = 3'd3;
    localparam logic [2:0] S_HALT     = 3'd4;

    localparam logic [1:0] OP_NEXT   = 2'b00;
    localparam logic [1:0] OP_BRANCH = 2'b01;
    localparam logic [1:0] OP_CALL   = 2'b10;

    logic [2:0]            state;
    logic [SP_W-1:0]       sp;
    logic [ADDR_WIDTH-1:0] stack [STACK_DEPTH];
    logic [ADDR_WIDTH-1:0] addr_inc;
    logic [ADDR_WIDTH-1:0] pop_data;
    logic                  push_en;

    // Return-address push decision and top-of-stack read
    always_comb begin
        addr_inc = cs_addr + ADDR_WIDTH'(1);
        push_en  = (state == S_EXEC) && !stall && (seq_op == OP_CALL) && (sp < SP_FULL);
        pop_data = stack[IDX_W'(sp - SP_W'(1))];
    end

    // Return stack storage; only the pointer is reset, contents persist
    always_ff @(posedge clk) begin
        if (push_en) begin
            stack[IDX_W'(sp)] <= addr_inc;
        end
    end

    // Load / fetch / execute / halt sequencing
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state        <= S_LOAD_WR;
            cs_addr      <= '0;
            cs_ready     <= 1'b0;
            cs_ram__w    <= 1'b1;
            cs_ram_wdata <= '0;
            cs_word      <= '0;
            halted       <= 1'b0;
            stack_err    <= 1'b0;
            sp           <= '0;
        end else begin
            case (state)
                S_LOAD_WR: begin
                    cs_ram_wdata <= rom_data;
                    cs_ram__w    <= 1'b0;
                    state        <= S_LOAD_ADV;
                end
                S_LOAD_ADV: begin
                    cs_ram__w <= 1'b1;
                    if (cs_addr == '1) begin
                        cs_addr  <= '0;
                        cs_ready <= 1'b1;
                        state    <= S_FETCH;
                    end else begin
                        cs_addr <= addr_inc;
                        state   <= S_LOAD_WR;
                    end
                end
                S_FETCH: begin
                    if (cs_addr == HALT_ADDR) begin
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else begin
                        cs_word <= cs_ram_data;
                        state   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (!stall) begin
                        case (seq_op)
                            OP_NEXT: begin
                                cs_addr <= (next_field != '0) ? next_field : ir;
                                state   <= S_FETCH;
                            end
                            OP_BRANCH: begin
                                cs_addr <= cond ? next_field : addr_inc;
                                state   <= S_FETCH;
                            end
                            OP_CALL: begin
                                if (sp < SP_FULL) begin
                                    cs_addr <= next_field;
                                    sp      <= sp + SP_W'(1);
                                    state   <= S_FETCH;
                                end else begin
                                    stack_err <= 1'b1;
                                    halted    <= 1'b1;
                                    state     <= S_HALT;
                                end
                            end
                            default: begin
                                if (sp != '0) begin
                                    cs_addr <= pop_data;
                                    sp      <= sp - SP_W'(1);
                                    state   <= S_FETCH;
                                end else begin
                                    stack_err <= 1'b1;
                                    halted    <= 1'b1;
                                    state     <= S_HALT;
                                end
                            end
                        endcase
                    end
                end
                default: begin
                    state <= S_HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed bench for microcode_sequencer: load timing, addressing modes,
// stall, call/return stack, halt and asynchronous reset.
module tb_microcode_sequencer;

    localparam int unsigned AW = 4;
    localparam int unsigned WW = 16;

    logic          clk = 1'b0;
    logic          _reset;
    logic [WW-1:0] rom_data;
    logic [WW-1:0] cs_ram_data;
    logic [WW-1:0] cs_ram_wdata;
    logic          cs_ram__w;
    logic [AW-1:0] cs_addr;
    logic          cs_ready;
    logic [WW-1:0] cs_word;
    logic [1:0]    seq_op;
    logic [AW-1:0] next_field;
    logic          cond;
    logic [AW-1:0] ir;
    logic          stall;
    logic          halted;
    logic          stack_err;

    microcode_sequencer #(
        .ADDR_WIDTH (AW),
        .WORD_WIDTH (WW),
        .STACK_DEPTH(2),
        .HALT_ADDR  (4'hE)
    ) dut (
        .clk         (clk),
        ._reset      (_reset),
        .rom_data    (rom_data),
        .cs_ram_data (cs_ram_data),
        .cs_ram_wdata(cs_ram_wdata),
        .cs_ram__w   (cs_ram__w),
        .cs_addr     (cs_addr),
        .cs_ready    (cs_ready),
        .cs_word     (cs_word),
        .seq_op      (seq_op),
        .next_field  (next_field),
        .cond        (cond),
        .ir          (ir),
        .stall       (stall),
        .halted      (halted),
        .stack_err   (stack_err)
    );

    always #5 clk = ~clk;

    // EPROM image: word[i] = i * 0x0101
    assign rom_data = 16'(cs_addr) * 16'h0101;

    // Control-store RAM model
    logic [WW-1:0] ram [16];
    assign cs_ram_data = ram[cs_addr];
    always @(posedge clk) begin
        if (!cs_ram__w) ram[cs_addr] <= cs_ram_wdata;
    end

    // Strobe-low cycle counter
    int strobes = 0;
    always @(negedge clk) begin
        if (_reset && !cs_ram__w) strobes <= strobes + 1;
    end

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t exp_q[$];

    logic [AW-1:0] m_addr;
    logic [AW-1:0] m_stack[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: observed %h expected none", obs);
        end else begin
            e = exp_q.pop_front();
            check(e.tag, obs, e.val);
        end
    endtask

    task automatic check_reset_vals();
        check("rst_cs_addr",   32'(cs_addr),      32'h0);
        check("rst_cs_ready",  32'(cs_ready),     32'h0);
        check("rst_cs_ram__w", 32'(cs_ram__w),    32'h1);
        check("rst_wdata",     32'(cs_ram_wdata), 32'h0);
        check("rst_cs_word",   32'(cs_word),      32'h0);
        check("rst_halted",    32'(halted),       32'h0);
        check("rst_stack_err", 32'(stack_err),    32'h0);
    endtask

    // Called just after a post-edge sample point; asserts reset mid-cycle
    task automatic apply_reset();
        #3;
        _reset = 1'b0;
        #1;
        check_reset_vals();
        m_stack.delete();
        m_addr = '0;
    endtask

    task automatic do_load();
        int cyc;
        int base;
        base = strobes;
        cyc  = 0;
        @(negedge clk);
        _reset = 1'b1;
        while (cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cs_ready) break;
        end
        check("load_cycles",  32'(cyc),            32'd32);
        check("load_strobes", 32'(strobes - base), 32'd16);
        check("load_addr",    32'(cs_addr),        32'h0);
        check("load_we_idle", 32'(cs_ram__w),      32'h1);
        m_addr = '0;
        m_stack.delete();
    endtask

    // One microinstruction: FETCH edge, optional stalled EXEC edges, EXEC edge
    task automatic step(input logic [1:0] op, input logic [AW-1:0] nf, input logic c,
                        input logic [AW-1:0] irv, input int unsigned stall_n);
        logic [AW-1:0] nxt;
        logic          err;
        err = 1'b0;
        nxt = m_addr;
        push_exp("fetch_word", 32'(16'(m_addr) * 16'h0101));
        case (op)
            2'b00: nxt = (nf != '0) ? nf : irv;
            2'b01: nxt = c ? nf : m_addr + 4'd1;
            2'b10: begin
                if (m_stack.size() < 2) begin
                    m_stack.push_back(m_addr + 4'd1);
                    nxt = nf;
                end else begin
                    err = 1'b1;
                end
            end
            default: begin
                if (m_stack.size() > 0) nxt = m_stack.pop_back();
                else err = 1'b1;
            end
        endcase
        push_exp("next_addr", 32'(nxt));
        push_exp("halted",    32'(err));
        push_exp("stack_err", 32'(err));
        seq_op     = op;
        next_field = nf;
        cond       = c;
        ir         = irv;
        stall      = (stall_n != 0);
        @(posedge clk);
        #1;
        pop_check(32'(cs_word));
        for (int i = 0; i < int'(stall_n); i++) begin
            @(posedge clk);
            #1;
            check("stall_hold", 32'(cs_addr), 32'(m_addr));
        end
        stall = 1'b0;
        @(posedge clk);
        #1;
        pop_check(32'(cs_addr));
        pop_check(32'(halted));
        pop_check(32'(stack_err));
        m_addr = nxt;
    endtask

    task automatic check_frozen(input logic [AW-1:0] a, input logic [WW-1:0] w, input logic e);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("frz_addr",   32'(cs_addr),   32'(a));
            check("frz_word",   32'(cs_word),   32'(w));
            check("frz_halted", 32'(halted),    32'h1);
            check("frz_err",    32'(stack_err), 32'(e));
            check("frz_we",     32'(cs_ram__w), 32'h1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        _reset     = 1'b0;
        seq_op     = 2'b00;
        next_field = '0;
        cond       = 1'b0;
        ir         = '0;
        stall      = 1'b0;
        m_addr     = '0;
        #12;
        check_reset_vals();

        // Boot load and RAM contents
        do_load();
        for (int i = 0; i < 16; i++) begin
            check("ram_image", 32'(ram[i]), 32'(16'(i) * 16'h0101));
        end

        // NEXT dispatch, NEXT direct, stall in EXEC (also raised during FETCH)
        step(2'b00, 4'h0, 1'b0, 4'h5, 0);
        step(2'b00, 4'h3, 1'b0, 4'h5, 0);
        step(2'b00, 4'hF, 1'b0, 4'h0, 4);

        // BRANCH not taken wraps, taken
        step(2'b01, 4'h9, 1'b0, 4'h0, 0);
        step(2'b01, 4'h9, 1'b1, 4'h0, 0);
        step(2'b00, 4'h2, 1'b0, 4'h0, 0);

        // Nested calls and returns, then overflow
        step(2'b10, 4'h8, 1'b0, 4'h0, 0);
        step(2'b10, 4'hC, 1'b0, 4'h0, 0);
        step(2'b11, 4'h0, 1'b0, 4'h0, 0);
        step(2'b11, 4'h0, 1'b0, 4'h0, 0);
        step(2'b10, 4'h8, 1'b0, 4'h0, 0);
        step(2'b10, 4'hC, 1'b0, 4'h0, 0);
        step(2'b10, 4'h1, 1'b0, 4'h0, 0);
        check_frozen(4'hC, 16'h0C0C, 1'b1);

        // Return with empty stack
        apply_reset();
        do_load();
        step(2'b11, 4'h0, 1'b0, 4'h0, 0);
        check_frozen(4'h0, 16'h0000, 1'b1);

        // Fetch of the halt address
        apply_reset();
        do_load();
        step(2'b00, 4'h3, 1'b0, 4'h0, 0);
        step(2'b00, 4'hE, 1'b0, 4'h0, 0);
        @(posedge clk);
        #1;
        check("halt_halted", 32'(halted),    32'h1);
        check("halt_err",    32'(stack_err), 32'h0);
        check("halt_word",   32'(cs_word),   32'h0303);
        check_frozen(4'hE, 16'h0303, 1'b0);

        // Reset in the middle of the load
        _reset = 1'b0;
        #1;
        check_reset_vals();
        @(negedge clk);
        _reset = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (cs_addr == 4'h7) break;
        end
        check("midload_addr", 32'(cs_addr), 32'h7);
        apply_reset();
        do_load();

        // Reset while in EXEC
        step(2'b00, 4'h3, 1'b0, 4'h0, 0);
        seq_op     = 2'b00;
        next_field = 4'h0;
        ir         = 4'h5;
        @(posedge clk);
        #1;
        check("exec_word", 32'(cs_word), 32'h0303);
        apply_reset();
        do_load();
        step(2'b00, 4'h0, 1'b0, 4'h5, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/microcode_sequencer.md
Name: microcode_sequencer

Overview:
Parametrised control-store sequencer for the microcoded core. After reset it copies the boot microcode from the control-store EPROM into the control-store RAM. It then sequences microinstructions through that RAM, latching each word for the datapath. Over the previous fixed 8-bit next-address/IR-dispatch scheme it adds conditional branching, a micro-subroutine call/return stack, a datapath stall, and a halt state.

Parameters:
ADDR_WIDTH, 8, control-store address width; the store holds 2^ADDR_WIDTH words
WORD_WIDTH, 64, microinstruction width
STACK_DEPTH, 4, micro-return stack entries (>=1)
HALT_ADDR, 8'hFE (ADDR_WIDTH bits), fetching this address halts the processor

Ports:
clk  in  1  system clock; all state updates on rising edge
_reset  in  1  asynchronous, active-low reset
rom_data  in  WORD_WIDTH  EPROM word at cs_addr (combinational read)
cs_ram_data  in  WORD_WIDTH  control-store RAM word at cs_addr (combinational read)
cs_ram_wdata  out  WORD_WIDTH  write data to control-store RAM
cs_ram__w  out  1  RAM write strobe, active-low
cs_addr  out  ADDR_WIDTH  registered control-store address (shared by ROM and RAM)
cs_ready  out  1  1 once the load completes
cs_word  out  WORD_WIDTH  latched microinstruction driving the datapath
seq_op  in  2  decoded from cs_word: 00 NEXT, 01 BRANCH, 10 CALL, 11 RET
next_field  in  ADDR_WIDTH  next-address field decoded from cs_word
cond  in  1  branch condition
ir  in  ADDR_WIDTH  instruction register, used for dispatch
stall  in  1  hold the current microinstruction
halted  out  1  processor halted
stack_err  out  1  sticky stack overflow/underflow flag

Behaviour:
- Reset (async, _reset=0) values:
  - state LOAD_WR; cs_addr=0; cs_ready=0; cs_ram__w=1; cs_ram_wdata=0; cs_word=0; halted=0; stack_err=0; sp=0.
  - A reset mid-load or mid-run restarts the copy from address 0.
- LOAD_WR: cs_ram_wdata<=rom_data; cs_ram__w<=0; go to LOAD_ADV.
- LOAD_ADV:
  - cs_ram__w<=1.
  - If cs_addr is all-ones: cs_addr<=0, cs_ready<=1, go to FETCH.
  - Otherwise cs_addr<=cs_addr+1, go to LOAD_WR.
  - The load takes exactly 2*2^ADDR_WIDTH cycles after reset release. cs_ram_wdata is stable for the whole strobe-low cycle.
- FETCH:
  - If cs_addr==HALT_ADDR: halted<=1, go to HALT; cs_word is not updated.
  - Otherwise cs_word<=cs_ram_data, go to EXEC.
  - stall is ignored in FETCH.
- EXEC:
  - stall=1: hold all state.
  - Otherwise cs_addr<=next address, go to FETCH. Each microinstruction therefore takes 2 cycles plus stall cycles.
- Next-address rules (incremented addresses are ADDR_WIDTH-wide and wrap, all-ones+1=0):
  - NEXT: next_field!=0 gives next_field; next_field==0 gives ir (opcode dispatch).
  - BRANCH: cond=1 gives next_field; cond=0 gives cs_addr+1.
  - CALL:
    - If sp<STACK_DEPTH: push cs_addr+1, sp++, jump to next_field.
    - If full: no push, stack_err<=1, halted<=1, go to HALT.
  - RET:
    - If sp>0: pop into cs_addr, sp--.
    - If empty: stack_err<=1, halted<=1, go to HALT.
- HALT: all outputs frozen and cs_ram__w=1 until reset; halted and stack_err stay asserted.
- Stack is LIFO; sp width is clog2(STACK_DEPTH+1). Stack contents are not cleared by reset, only sp.
- cs_ram__w is 0 only in the cycle following LOAD_WR entry and is never 0 once cs_ready=1.

Test Plan:
1. ADDR_WIDTH=4, ROM word[i]=i*0x0101 -> 16 strobe-low pulses, RAM[i] matches, cs_ready rises exactly 32 cycles after _reset release, cs_addr=0.
2. Run with word0: seq_op=NEXT, next_field=0, ir=5 -> cs_addr=5 after 2 cycles; next_field=3 -> cs_addr=3; stall held 4 cycles in EXEC -> cs_addr changes 4 cycles later.
3. BRANCH at 0xF with cond=0 -> cs_addr wraps to 0x0; cond=1, next_field=0x9 -> 0x9.
4. STACK_DEPTH=2: CALL at 2->8, CALL at 8->C, RET -> 9, RET -> 3; third nested CALL -> stack_err=1, halted=1, cs_addr frozen.
5. RET with sp=0 -> stack_err=1, halted=1; fetch HALT_ADDR (0xE) with no error -> halted=1, stack_err=0, cs_word unchanged.
6. Assert _reset mid-load (address 7) and again mid-run (in EXEC) -> outputs clear asynchronously, load restarts at 0, full 32-cycle load repeats.
